// File: rtl/data_mem_resp_pkg.sv
// Shared types and defaults for the data memory responder: FSM states,
// the response record carried down the latency pipe, and a byte-merge helper.
package data_mem_resp_pkg;

  localparam int unsigned DefMemWords    = 1024;
  localparam int unsigned DefGntStall    = 0;
  localparam int unsigned DefRespLatency = 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store data bus between a core (master) and the memory responder (slave).
interface data_mem_responder_if;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        proto_err_o;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, proto_err_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, proto_err_o
  );

endinterface

// File: rtl/data_mem_resp_pipe.sv
// Fixed-latency response delay line; every stage clears synchronously on reset
// so in-flight responses are dropped.
module data_mem_resp_pipe
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned Depth = DefRespLatency
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  resp_t resp_in,
  output resp_t resp_out
);

  resp_t stage [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) stage[i] <= '0;
    end else begin
      stage[0] <= resp_in;
      for (int unsigned i = 1; i < Depth; i++) stage[i] <= stage[i-1];
    end
  end

  assign resp_out = stage[Depth-1];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory model for a load/store unit: configurable grant stall,
// byte-enabled word array, fixed-latency in-order responses, protocol checker.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned MemWords    = DefMemWords,
  parameter int unsigned GntStall    = DefGntStall,
  parameter int unsigned RespLatency = DefRespLatency
) (
  input logic           clk_i,
  input logic           rst_i,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(MemWords);

  state_t         state_q, state_d;
  logic [2:0]     stall_cnt;
  logic           gnt;
  logic           in_range;
  logic           viol;
  logic           proto_err;
  logic [AW-1:0]  widx;
  logic           prev_we;
  logic [3:0]     prev_be;
  logic [31:0]    prev_addr;
  logic [31:0]    prev_wdata;
  logic [31:0]    mem [MemWords];
  resp_t          resp_in;
  resp_t          resp_out;

  // Grant is combinational from req but suppressed during reset.
  assign gnt      = bus.data_req_i && !rst_i && (stall_cnt == 3'(GntStall));
  assign widx     = bus.data_addr_i[AW+1:2];
  assign in_range = (bus.data_addr_i[31:AW+2] == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i)                         stall_cnt <= '0;
    else if (bus.data_req_i && !gnt)   stall_cnt <= stall_cnt + 3'd1;
    else                               stall_cnt <= '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    viol    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.data_req_i && !gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        viol = !bus.data_req_i
            || (bus.data_we_i    != prev_we)
            || (bus.data_be_i    != prev_be)
            || (bus.data_addr_i  != prev_addr)
            || (bus.data_wdata_i != prev_wdata);
        if (!bus.data_req_i || gnt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Previous-cycle request attributes, compared while waiting for a grant.
  always_ff @(posedge clk_i) begin
    prev_we    <= bus.data_we_i;
    prev_be    <= bus.data_be_i;
    prev_addr  <= bus.data_addr_i;
    prev_wdata <= bus.data_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     proto_err <= 1'b0;
    else if (viol) proto_err <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (gnt && bus.data_we_i && in_range)
      mem[widx] <= be_merge(mem[widx], bus.data_wdata_i, bus.data_be_i);
  end

  always_comb begin
    resp_in = '0;
    if (gnt) begin
      resp_in.valid = 1'b1;
      resp_in.err   = !in_range;
      if (in_range && !bus.data_we_i) resp_in.rdata = mem[widx];
    end
  end

  data_mem_resp_pipe #(
    .Depth (RespLatency)
  ) u_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .resp_in  (resp_in),
    .resp_out (resp_out)
  );

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = resp_out.valid;
  assign bus.data_err_o    = resp_out.err;
  assign bus.data_rdata_o  = resp_out.rdata;
  assign bus.proto_err_o   = proto_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three configurations, directed vector table,
// hand sequences for stall/protocol/reset, and randomized traffic vs a model.
module tb_data_mem_responder;

  localparam int unsigned STALL [3] = '{0, 2, 0};
  localparam int unsigned LAT   [3] = '{1, 1, 3};
  localparam int unsigned WORDS [3] = '{1024, 64, 64};
  localparam int unsigned MW        = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();
  data_mem_responder_if ifc ();

  logic [2:0]       req_d = '0;
  logic [2:0]       we_d  = '0;
  logic [2:0][3:0]  be_d  = '0;
  logic [2:0][31:0] addr_d  = '0;
  logic [2:0][31:0] wdata_d = '0;
  logic [2:0]       gnt_s, rvalid_s, err_s, perr_s;
  logic [2:0][31:0] rdata_s;

  assign ifa.data_req_i = req_d[0];  assign ifa.data_we_i = we_d[0];
  assign ifa.data_be_i  = be_d[0];   assign ifa.data_addr_i = addr_d[0];
  assign ifa.data_wdata_i = wdata_d[0];
  assign ifb.data_req_i = req_d[1];  assign ifb.data_we_i = we_d[1];
  assign ifb.data_be_i  = be_d[1];   assign ifb.data_addr_i = addr_d[1];
  assign ifb.data_wdata_i = wdata_d[1];
  assign ifc.data_req_i = req_d[2];  assign ifc.data_we_i = we_d[2];
  assign ifc.data_be_i  = be_d[2];   assign ifc.data_addr_i = addr_d[2];
  assign ifc.data_wdata_i = wdata_d[2];

  assign gnt_s    = {ifc.data_gnt_o,    ifb.data_gnt_o,    ifa.data_gnt_o};
  assign rvalid_s = {ifc.data_rvalid_o, ifb.data_rvalid_o, ifa.data_rvalid_o};
  assign err_s    = {ifc.data_err_o,    ifb.data_err_o,    ifa.data_err_o};
  assign perr_s   = {ifc.proto_err_o,   ifb.proto_err_o,   ifa.proto_err_o};
  assign rdata_s  = {ifc.data_rdata_o,  ifb.data_rdata_o,  ifa.data_rdata_o};

  data_mem_responder #(.MemWords(1024), .GntStall(0), .RespLatency(1))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  data_mem_responder #(.MemWords(64), .GntStall(2), .RespLatency(1))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  data_mem_responder #(.MemWords(64), .GntStall(0), .RespLatency(3))
    dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: word array with per-byte "written" flags, plus a queue
  // of responses due at absolute cycle numbers.
  logic [31:0]  mdl  [3][MW];
  logic [3:0]   kb   [3][MW];
  int unsigned  held [3];

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    bit          known;
  } exp_t;
  exp_t exp_q [$];

  typedef struct {
    bit          req;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          g;
    bit          rv;
    bit          er;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int k, input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic        eg;
    int unsigned idx;
    @(posedge clk); #1; cyc++;
    req_d[k] = req; we_d[k] = we; be_d[k] = be; addr_d[k] = addr; wdata_d[k] = wdata;
    @(negedge clk);
    eg = req && (held[k] == STALL[k]);
    check("gnt", 32'(gnt_s[k]), 32'(eg));
    held[k] = (req && !eg) ? held[k] + 1 : 0;
    if (eg) begin
      idx     = addr >> 2;
      e.due   = cyc + int'(LAT[k]);
      e.err   = 1'b0;
      e.rdata = '0;
      e.known = 1'b1;
      if (idx >= WORDS[k]) e.err = 1'b1;
      else if (idx >= MW) e.known = 1'b0;
      else if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) begin
            mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
            kb[k][idx][b] = 1'b1;
          end
      end else begin
        e.rdata = mdl[k][idx];
        e.known = (kb[k][idx] == 4'hF);
      end
      exp_q.push_back(e);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("rvalid", 32'(rvalid_s[k]), 32'd1);
      check("err", 32'(err_s[k]), 32'(e.err));
      if (e.known) check("rdata", rdata_s[k], e.rdata);
    end else begin
      check("rvalid_idle", 32'(rvalid_s[k]), 32'd0);
      check("rdata_idle", rdata_s[k], 32'd0);
      check("err_idle", 32'(err_s[k]), 32'd0);
    end
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; cyc++;
      rst = 1'b1; req_d = '1; we_d = '0; addr_d = '0;
      @(negedge clk);
      check("gnt_in_reset", 32'(gnt_s), 32'd0);
      if (c > 0) begin
        check("rvalid_in_reset", 32'(rvalid_s), 32'd0);
        check("err_in_reset", 32'(err_s), 32'd0);
        check("perr_in_reset", 32'(perr_s), 32'd0);
        for (int k = 0; k < 3; k++) check("rdata_in_reset", rdata_s[k], 32'd0);
      end
    end
    @(posedge clk); #1; cyc++;
    rst = 1'b0; req_d = '0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) held[k] = 0;
  endtask

  task automatic random_run(input int k, input int n);
    logic        r, w;
    logic [3:0]  be;
    logic [31:0] a;
    for (int i = 0; i < int'(MW); i++) step(k, 1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom());
    for (int i = 0; i < n; i++) begin
      r  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'(WORDS[k] * 4);
      else                           a = 32'($urandom_range(0, MW * 4 - 1));
      step(k, r, w, be, a, $urandom());
    end
    idle(k, int'(LAT[k]) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      held[k] = 0;
      for (int w = 0; w < int'(MW); w++) begin mdl[k][w] = '0; kb[k][w] = '0; end
    end

    vecs[0]  = '{1, 1, 4'hF, 32'h10,   32'hDEADBEEF, 1, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 4'hF, 32'h10,   32'h0,        1, 1, 0, 32'h0};
    vecs[2]  = '{0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 0, 32'hDEADBEEF};
    vecs[3]  = '{1, 1, 4'hF, 32'h20,   32'h11223344, 1, 0, 0, 32'h0};
    vecs[4]  = '{1, 1, 4'h2, 32'h20,   32'h0000AA00, 1, 1, 0, 32'h0};
    vecs[5]  = '{1, 0, 4'hF, 32'h20,   32'h0,        1, 1, 0, 32'h0};
    vecs[6]  = '{1, 1, 4'hF, 32'h0,    32'h01234567, 1, 1, 0, 32'h1122AA44};
    vecs[7]  = '{1, 0, 4'hF, 32'h1000, 32'h0,        1, 1, 0, 32'h0};
    vecs[8]  = '{1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1, 1, 1, 32'h0};
    vecs[9]  = '{1, 0, 4'hF, 32'h0,    32'h0,        1, 1, 1, 32'h0};
    vecs[10] = '{0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 0, 32'h01234567};
    vecs[11] = '{0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 32'h0};

    do_reset();

    // Directed table on the zero-stall, latency-1 instance.
    for (int i = 0; i < 12; i++) begin
      step(0, vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      check("vec_gnt", 32'(gnt_s[0]), 32'(vecs[i].g));
      check("vec_rvalid", 32'(rvalid_s[0]), 32'(vecs[i].rv));
      check("vec_err", 32'(err_s[0]), 32'(vecs[i].er));
      check("vec_rdata", rdata_s[0], vecs[i].rd);
    end
    check("vec_perr", 32'(perr_s[0]), 32'd0);

    random_run(0, 250);

    // Latency-3: back-to-back reads come back on consecutive cycles, in order.
    step(2, 1, 1, 4'hF, 32'h0, 32'hA0A0A0A0);
    step(2, 1, 1, 4'hF, 32'h4, 32'hB1B1B1B1);
    step(2, 1, 1, 4'hF, 32'h8, 32'hC2C2C2C2);
    idle(2, 3);
    step(2, 1, 0, 4'hF, 32'h0, 32'h0);
    step(2, 1, 0, 4'hF, 32'h4, 32'h0);
    step(2, 1, 0, 4'hF, 32'h8, 32'h0);
    idle(2, 4);
    random_run(2, 250);

    // Stall-2: grant on the third held cycle, data intact through the stall.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 4'hF, 32'h8, 32'h5A5A5A5A);
    idle(1, 2);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'hF, 32'h8, 32'h0);
    idle(1, 2);
    check("perr_clean", 32'(perr_s[1]), 32'd0);
    step(1, 1, 0, 4'hF, 32'h8, 32'h0);
    step(1, 1, 0, 4'hF, 32'hC, 32'h0);
    step(1, 1, 0, 4'hF, 32'hC, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1);
      check("perr_addr_change", 32'(perr_s[1]), 32'd1);
    end
    do_reset();
    check("perr_after_reset", 32'(perr_s[1]), 32'd0);
    step(1, 1, 0, 4'hF, 32'h8, 32'h0);
    idle(1, 2);
    check("perr_req_drop", 32'(perr_s[1]), 32'd1);
    do_reset();

    // Reset with two responses in flight on the latency-3 instance.
    step(2, 1, 0, 4'hF, 32'h0, 32'h0);
    step(2, 1, 0, 4'hF, 32'h4, 32'h0);
    do_reset();
    idle(2, 5);
    check("perr_c_after_reset", 32'(perr_s[2]), 32'd0);
    step(2, 1, 0, 4'hF, 32'h4, 32'h0);
    idle(2, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MemWords, 1024, number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter GntStall, 0, number of cycles req must be held before gnt (0..7).
REQ-003 SHALL have parameter RespLatency, 1, cycles from gnt to rvalid (1..4).
REQ-004 SHALL have clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have data_req_i  in  1  request from load/store unit.
REQ-007 SHALL have data_we_i  in  1  1=write, 0=read.
REQ-008 SHALL have data_be_i  in  4  byte enables.
REQ-009 SHALL have data_addr_i  in  32  byte address; bits [1:0] ignored.
REQ-010 SHALL have data_wdata_i  in  32  write data.
REQ-011 SHALL have data_gnt_o  out  1  request accepted this cycle.
REQ-012 SHALL have data_rvalid_o  out  1  response valid.
REQ-013 SHALL have data_rdata_o  out  32  read data, 0 on writes and errors.
REQ-014 SHALL have data_err_o  out  1  response error, qualified by rvalid.
REQ-015 SHALL have proto_err_o  out  1  sticky protocol-violation flag.

Function
REQ-016 SHALL keep stall counter stall_cnt (3 bits): increments while req && !gnt, clears on gnt or !req.
REQ-017 SHALL drive data_gnt_o = data_req_i && (stall_cnt == GntStall) combinationally; GntStall=0 grants in request cycle.
REQ-018 SHALL use FSM IDLE/WAIT: IDLE->WAIT on req && !gnt; WAIT->IDLE on gnt; WAIT->IDLE on req drop (violation, REQ-024).
REQ-019 SHALL decode word index = data_addr_i[31:2]; index >= MemWords is out-of-range.
REQ-020 SHALL, on granted in-range write, update only bytes with be set, in the grant cycle; result visible to any later-granted read.
REQ-021 SHALL, on granted read, sample array word in grant cycle; granted out-of-range access performs no write and yields err=1, rdata=0.
REQ-022 SHALL deliver exactly one response per grant (reads and writes) exactly RespLatency cycles after the grant cycle, in order.
REQ-023 SHALL support a new grant every cycle; responses pipelined, no back-pressure.
REQ-024 SHALL set proto_err_o, held until reset, when in WAIT: req drops before gnt, or we/addr/be/wdata differ from previous cycle.
REQ-025 SHALL keep rvalid low and rdata/err at 0 in cycles without a response.

Reset
REQ-026 SHALL, while rst_i high at clock edge: FSM->IDLE, stall_cnt=0, response pipeline cleared, proto_err_o=0, outputs rvalid/err=0, rdata=0.
REQ-027 SHALL discard in-flight responses on reset mid-operation; no rvalid after reset for pre-reset grants.
REQ-028 SHALL NOT clear array contents on reset; contents undefined until written.
REQ-029 SHALL still drive gnt combinationally from req during reset? No: SHALL force data_gnt_o=0 while rst_i high.

Structure
REQ-030 SHALL place FSM state enum, response struct {valid, err, rdata}, and parameter defaults in package data_mem_resp_pkg.
REQ-031 SHALL implement response delay as sub-module data_mem_resp_pipe (RespLatency-stage shift register of response struct, synchronous clear).
REQ-032 SHALL infer array as synthesizable byte-enabled register/RAM, no vendor macros.

Verification
REQ-033 GntStall=0, RespLatency=1: write 0xDEADBEEF be=0xF to 0x10, next cycle read 0x10 -> gnt same cycle each, rvalid cycle+1, rdata=0xDEADBEEF, err=0.
REQ-034 GntStall=2: req held 3 cycles stable -> gnt only third cycle, proto_err_o stays 0; change addr in cycle 2 -> proto_err_o=1 until reset.
REQ-035 Partial write be=0x2 data 0x0000AA00 over 0x11223344 at 0x20, read back -> rdata=0x1122AA44.
REQ-036 MemWords=1024: read 0x1000 -> rvalid with err=1, rdata=0; write 0x1000 leaves word 0 unchanged.
REQ-037 RespLatency=3: reads granted back-to-back at 0x0,0x4,0x8 -> three consecutive rvalid cycles, in order, starting 3 cycles after first gnt.
REQ-038 Assert rst_i with 2 responses in flight -> no rvalid after reset, proto_err_o=0, gnt=0 during reset.
